// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared AES definitions: FSM states, round count, Rcon and GF(2^8) / S-box helpers.
// S-boxes are computed (multiplicative inverse plus affine map) rather than tabulated.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } aes_state_e;

  localparam int AES_ROUNDS = 10;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes128_decrypt_iter_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Purely combinational, zero latency; no flow control of its own.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] ark;

  // byte 4*c+r sits at row r, column c; InvShiftRows pulls row r from column c-r
  always_comb begin
    ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(4*c+r) -: 8] = inv_sbox(state_in[127-8*(4*((c-r+4)%4)+r) -: 8])
                                  ^ round_key[127-8*(4*c+r) -: 8];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    state_out = ark;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = ark[127-32*c -: 8];
        a1 = ark[119-32*c -: 8];
        a2 = ark[111-32*c -: 8];
        a3 = ark[103-32*c -: 8];
        state_out[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        state_out[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        state_out[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        state_out[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
  end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to k10, then 10 inverse rounds, one per cycle.
// Latency 20 cycles accept-to-out_valid (10 on a key-cache hit when AES_DEC_KEYCACHE_EN is defined).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready is sampled high.
module aes128_decrypt_iter
  import aes_pkg::*;
#(
  parameter int ROUNDS        = 10,
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes128_decrypt_iter supports only ROUNDS == 10");
  end

  aes_state_e   st_q, st_nxt;
  logic [127:0] key_q, key_nxt;
  logic [127:0] state_q, state_nxt;
  logic [127:0] dout_nxt;
  logic [3:0]   rc_q, rc_nxt;
  logic [127:0] k_fwd, k_prev, round_out;
  logic         cache_hit;
  logic [127:0] cached_k10;

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: the last word must be recovered before the first
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign k_fwd  = key_fwd(key_q, rcon(rc_q));
  assign k_prev = key_inv(key_q, rcon(rc_q));

  aes_inv_round u_inv_round (
    .state_in  (state_q),
    .round_key (k_prev),
    .last      (rc_q == 4'd1),
    .state_out (round_out)
  );

`ifdef AES_DEC_KEYCACHE_EN
  logic         cache_vld;
  logic [127:0] cache_key;
  logic [127:0] cache_k10;

  assign cache_hit  = cache_vld && (key_in == cache_key);
  assign cached_k10 = cache_k10;

  // Key is captured at accept; k10 and the valid flag only once expansion completes
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_k10 <= '0;
    end else if (st_q == IDLE && in_valid && !cache_hit) begin
      cache_vld <= 1'b0;
      cache_key <= key_in;
    end else if (st_q == KEXP && rc_q == 4'(ROUNDS)) begin
      cache_vld <= 1'b1;
      cache_k10 <= k_fwd;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cached_k10 = '0;
`endif

  always_comb begin
    st_nxt    = st_q;
    key_nxt   = key_q;
    state_nxt = state_q;
    rc_nxt    = rc_q;
    dout_nxt  = data_out;
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          if (cache_hit) begin
            state_nxt = data_in ^ cached_k10;
            key_nxt   = cached_k10;
            rc_nxt    = 4'(ROUNDS);
            st_nxt    = DEC;
          end else begin
            state_nxt = data_in;
            key_nxt   = key_in;
            rc_nxt    = 4'd1;
            st_nxt    = KEXP;
          end
        end
      end
      KEXP: begin
        key_nxt = k_fwd;
        if (rc_q == 4'(ROUNDS)) begin
          state_nxt = state_q ^ k_fwd;
          st_nxt    = DEC;
        end else begin
          rc_nxt = rc_q + 4'd1;
        end
      end
      DEC: begin
        state_nxt = round_out;
        key_nxt   = k_prev;
        rc_nxt    = rc_q - 4'd1;
        if (rc_q == 4'd1) begin
          dout_nxt = round_out;
          st_nxt   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          st_nxt = IDLE;
          if (CLEAR_ON_DONE) dout_nxt = '0;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      key_q    <= '0;
      state_q  <= '0;
      rc_q     <= '0;
      data_out <= '0;
    end else begin
      st_q     <= st_nxt;
      key_q    <= key_nxt;
      state_q  <= state_nxt;
      rc_q     <= rc_nxt;
      data_out <= dout_nxt;
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q == KEXP) || (st_q == DEC);

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter using FIPS-197 and SP800-38A vectors.
module tb_aes128_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] exp_q[$];
  int           lat_q[$];

`ifdef AES_DEC_KEYCACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  bit           mc_vld = 1'b0;
  logic [127:0] mc_key = '0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT_S1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_S1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_S2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT_S2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  aes128_decrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge that retires the result
  task automatic run_vec(input string tag, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, input int hold, input bit churn,
                         input bit chk_k10, input logic [127:0] k10);
    int guard;
    int cycles;
    int lat;
    logic [127:0] held;
    data_in  = ct;
    key_in   = key;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check({tag, "_accept"}, 128'(in_ready), 128'd1);
    lat = (CACHE_EN && mc_vld && mc_key == key) ? 10 : 20;
    exp_q.push_back(pt);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 60) begin
      if (churn) begin
        data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cycles++;
      if (chk_k10 && cycles == 10) check({tag, "_k10"}, dut.key_q, k10);
    end
    in_valid = 1'b0;
    if (lat == 20) begin
      mc_vld = 1'b1;
      mc_key = key;
    end
    check({tag, "_lat"}, 128'(cycles), 128'(lat_q.pop_front()));
    check({tag, "_pt"}, data_out, exp_q.pop_front());
    held = data_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_bp_dout"}, data_out, held);
      check({tag, "_bp_inrdy"}, 128'(in_ready), 128'd0);
      check({tag, "_bp_ovld"}, 128'(out_valid), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ret_ovld"}, 128'(out_valid), 128'd0);
    check({tag, "_ret_inrdy"}, 128'(in_ready), 128'd1);
    check({tag, "_ret_clr"}, data_out, 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    key_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inrdy", 128'(in_ready), 128'd1);
    check("rst_ovld", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_dout", data_out, 128'd0);
    check("rst_key", dut.key_q, 128'd0);
    rst = 1'b0;

    run_vec("c1", K_C1, CT_C1, PT_C1, 0, 1'b0, 1'b0, '0);
    run_vec("c1_again", K_C1, CT_C1, PT_C1, 0, 1'b0, 1'b0, '0);
    run_vec("appb", K_B, CT_B, PT_B, 0, 1'b0, 1'b1, K10_B);
    run_vec("sp_blk1", K_B, CT_S1, PT_S1, 0, 1'b0, 1'b0, '0);
    run_vec("c1_bp", K_C1, CT_C1, PT_C1, 15, 1'b0, 1'b0, '0);

    // abort in the middle of the inverse rounds
    data_in  = CT_C1;
    key_in   = K_C1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mc_vld = 1'b0;
    check("mid_rst_inrdy", 128'(in_ready), 128'd1);
    check("mid_rst_ovld", 128'(out_valid), 128'd0);
    check("mid_rst_dout", data_out, 128'd0);
    run_vec("c1_after_rst", K_C1, CT_C1, PT_C1, 0, 1'b0, 1'b0, '0);

    run_vec("c1_churn", K_C1, CT_C1, PT_C1, 0, 1'b1, 1'b0, '0);
    run_vec("sp_blk2", K_B, CT_S2, PT_S2, 0, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_iter.md
Name: aes128_decrypt_iter

Overview:
- Iterative AES-128 decryption core; inverse counterpart of the AES-128 encryption round datapath.
- Accepts a 128-bit ciphertext and a 128-bit cipher key through a valid/ready handshake.
- Expands the key forward to round key 10, then runs 10 inverse rounds, one per cycle, regenerating round keys backwards on the fly.
- Sits beside the encryption round chain as the decrypt path of the AES block.

Parameters:
- ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal, elaboration error otherwise.
- CLEAR_ON_DONE, 1, when 1 data_out is zeroed on the DONE->IDLE transition; when 0 it holds the last plaintext.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext/key present.
- in_ready  output  1  core can accept; high only in IDLE.
- data_in  input  128  ciphertext, byte 0 in bits [127:120] (FIPS-197 order).
- key_in  input  128  cipher key, same byte order.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- data_out  output  128  plaintext.
- busy  output  1  high in KEXP or DEC.

Behaviour:
- Reset values (rst sampled at rising clk): state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, round counter rc=0, key register=0, state register=0. Reset mid-operation aborts immediately; no partial output is produced.
- IDLE: in_ready=1. An accept occurs when in_valid&&in_ready at edge E0. At E0: latch data_in, latch key_in into the key register, rc<=1, go to KEXP.
- KEXP: 10 cycles, at edges E1..E10. Each edge: key <= forward expansion of key with Rcon[rc]; rc++. At E10 (rc==10): key<=k10, state<=ct^k10, rc<=10, go to DEC.
- DEC: 10 cycles, at edges E11..E20. Combinationally compute k_{rc-1} from the key register using the inverse schedule: w[i]=w[i+4]^w[i+3] for non-first words; first word w[0]=w[4]^SubWord(RotWord(w[3]))^Rcon[rc], where w[3] is recovered first.
- Each DEC edge: state <= InvMixColumns(InvSubBytes(InvShiftRows(state))^k_{rc-1}); key<=k_{rc-1}; rc--.
- At rc==1, InvMixColumns is skipped, data_out<=result, and the core goes to DONE.
- Latency: out_valid is high after edge E20, i.e. 20 cycles after the accepting edge.
- DONE: out_valid=1, data_out stable. When out_ready is sampled high: out_valid<=0, go to IDLE.
- in_ready stays low in DONE. An in_valid arriving in DONE is accepted no earlier than the cycle after the return to IDLE.
- Inputs are ignored (not sampled) outside IDLE. Changing data_in or key_in mid-operation has no effect.
- out_ready while not in DONE is ignored.
- All XOR/GF(2^8) arithmetic is bytewise; the reduction polynomial is 0x11B.

Optional Feature:
- Macro AES_DEC_KEYCACHE_EN.
- When defined: the core keeps a cached cipher key, cached k10 and a valid flag (cleared by rst).
- On accept, if the flag is valid and key_in equals the cached key, KEXP is skipped: at E0 state<=ct^cached_k10, key<=cached_k10, rc<=10, go to DEC. Latency becomes 10 cycles.
- On a miss, the normal path runs, and the cache is written at E10.
- When undefined: no cache storage; latency is always 20 cycles.

Decomposition:
- Package aes_pkg holds:
  - FSM state enum (IDLE, KEXP, DEC, DONE).
  - AES_ROUNDS=10.
  - Rcon table [1..10].
  - xtime/gmul functions.
  - Forward and inverse S-box functions.
- Sub-module aes_inv_round (combinational): inputs state, round key, last-round flag; output next state. It performs InvShiftRows, InvSubBytes, AddRoundKey and conditional InvMixColumns.
- The key schedule stays in the top module.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff, out_valid exactly 20 cycles after accept.
- FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734. Internal key register after E10 must equal d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid -> data_out stable, in_ready=0 throughout. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Reset mid-DEC: assert rst at E15 -> next cycle IDLE, out_valid=0, data_out=0. Re-issue the C.1 vector -> correct pt after 20 cycles.
- Input churn: toggle data_in/key_in randomly during KEXP/DEC -> result still equals the originally accepted vector's plaintext.
- With AES_DEC_KEYCACHE_EN: C.1 twice back-to-back -> first 20-cycle latency, second 10-cycle latency. Same ct under a different key -> 20 cycles and correct result.
